rlbp_seq_ctrl: RTL

Acquisition sequencer for the RLBP pixel macro. It takes the per-signal time_up/time_down window registers programmed over Wishbone and runs a timebase counter for a programmed number of pixel cycles. From the counter it generates the eight analog front-end control strobes (Vd1, Vd2, Sw1, Sw2, Sh, Sh_cmp, Sh_rst, counter_rst). Between pixel cycles it hands off to the parallel-to-serial stage. It sits between the Wishbone register file and the rlbp datapath, replacing free-running strobe generation with a start/done-controlled sequence.

---
 rtl/rlbp_seq_pkg.sv | 25 ++
 rtl/rlbp_seq_ctrl_win.sv | 31 +++
 rtl/rlbp_seq_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rlbp_seq_pkg.sv
// Shared types and defaults for the RLBP acquisition sequencer.
// Channel indices follow the ctrl_o bit order.
package rlbp_seq_pkg;

  localparam int DEF_CW  = 11;
  localparam int DEF_NCH = 8;
  localparam int DEF_ITW = 8;

  localparam int CH_VD1     = 0;
  localparam int CH_VD2     = 1;
  localparam int CH_SW1     = 2;
  localparam int CH_SW2     = 3;
  localparam int CH_SH      = 4;
  localparam int CH_SH_CMP  = 5;
  localparam int CH_SH_RST  = 6;
  localparam int CH_CNT_RST = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    XFER,
    DONE
  } state_t;

endpackage

// File: rtl/rlbp_seq_ctrl_win.sv
// Per-channel window comparator for the RLBP sequencer.
// Registers the strobe from the next count so it lines up with count_o.
module rlbp_win_cmp
  import rlbp_seq_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] i_cnt_nxt,
  input  logic [CW-1:0] i_up,
  input  logic [CW-1:0] i_down,
  input  logic          i_run_en,
  output logic          o_strobe
);

  logic w_hit;
  logic r_strobe;

  assign w_hit = i_run_en
              && (i_up <= i_cnt_nxt)
              && (i_cnt_nxt < i_down);

  always_ff @(posedge clk) begin
    if (rst) r_strobe <= 1'b0;
    else     r_strobe <= w_hit;
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/rlbp_seq_ctrl.sv
// RLBP acquisition sequencer: timebase, strobe windows and
// start/done control with serializer hand-off between pixel cycles.
module rlbp_seq_ctrl
  import rlbp_seq_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int NCH = DEF_NCH,
  parameter int ITW = DEF_ITW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*CW-1:0] cfg_up,
  input  logic [NCH*CW-1:0] cfg_down,
  input  logic [CW-1:0]     cfg_period,
  input  logic [ITW-1:0]    cfg_iters,
  input  logic              start,
  input  logic              abort,
  input  logic              p2s_ready,
  output logic              p2s_en,
  output logic [NCH-1:0]    ctrl_o,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     count_o,
  output logic [ITW-1:0]    iter_o
);

  localparam logic [CW-1:0]  C_ONE = CW'(1);
  localparam logic [ITW-1:0] I_ONE = ITW'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NCH*CW-1:0] r_up;
  logic [NCH*CW-1:0] r_down;
  logic [NCH*CW-1:0] w_up;
  logic [NCH*CW-1:0] w_down;
  logic [CW-1:0]     r_period;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic [ITW-1:0]    r_iters;
  logic [ITW-1:0]    r_iter;
  logic [ITW-1:0]    w_iter_nxt;
  logic              r_p2s_en;
  logic              r_busy;
  logic              r_done;
  logic              w_p2s_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_run_en;
  logic              w_load;
  logic              w_start_ok;
  logic              w_wrap;
  logic              w_last;

  assign w_start_ok = start
                   && (cfg_period != '0)
                   && (cfg_iters != '0);
  assign w_wrap = r_count == r_period - C_ONE;
  assign w_last = r_iter == r_iters - I_ONE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_start_ok) w_state_nxt = RUN;
      RUN:  if (w_wrap) w_state_nxt = XFER;
      // ready is ignored during the launch cycle itself
      XFER: if (!r_p2s_en && p2s_ready)
              w_state_nxt = w_last ? DONE : RUN;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  always_comb begin
    w_busy_nxt  = w_state_nxt != IDLE;
    w_done_nxt  = w_state_nxt == DONE;
    w_run_en    = w_state_nxt == RUN;
    w_p2s_nxt   = (r_state == RUN) && (w_state_nxt == XFER);
    w_load      = (r_state == IDLE) && (w_state_nxt == RUN);
    w_count_nxt = '0;
    if ((r_state == RUN) && (w_state_nxt == RUN))
      w_count_nxt = r_count + C_ONE;
    w_iter_nxt = r_iter;
    if (w_state_nxt == IDLE)
      w_iter_nxt = '0;
    else if ((r_state == XFER) && (w_state_nxt == RUN))
      w_iter_nxt = r_iter + I_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_iter   <= '0;
      r_p2s_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_iter   <= w_iter_nxt;
      r_p2s_en <= w_p2s_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up     <= '0;
      r_down   <= '0;
      r_period <= '0;
      r_iters  <= '0;
    end else if (w_load) begin
      r_up     <= cfg_up;
      r_down   <= cfg_down;
      r_period <= cfg_period;
      r_iters  <= cfg_iters;
    end
  end

  // The first RUN cycle is computed before the shadows are loaded.
  assign w_up   = (r_state == IDLE) ? cfg_up   : r_up;
  assign w_down = (r_state == IDLE) ? cfg_down : r_down;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    rlbp_win_cmp #(.CW(CW)) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .i_cnt_nxt (w_count_nxt),
      .i_up      (w_up[g*CW +: CW]),
      .i_down    (w_down[g*CW +: CW]),
      .i_run_en  (w_run_en),
      .o_strobe  (ctrl_o[g])
    );
  end

  assign p2s_en  = r_p2s_en;
  assign busy    = r_busy;
  assign done    = r_done;
  assign count_o = r_count;
  assign iter_o  = r_iter;

endmodule
